// File: rtl/xy_position_datapath_if.sv
// Purpose : Command/status bundle between the XY motion FSM and the position
//           datapath.
// Signals : init, capt_enbl, x/y_count_en, x/y_up1_dwn0, x/y_target_in (FSM -> datapath)
//           x/y_pos, x/y_target, x/y_comp_eq/gt/lt, step_tick (datapath -> FSM)
// Modports: master = FSM side, slave = datapath side.
interface xy_position_datapath_if #(
    parameter int unsigned WIDTH = 8
);
    logic             init;
    logic             capt_enbl;
    logic             x_count_en;
    logic             x_up1_dwn0;
    logic             y_count_en;
    logic             y_up1_dwn0;
    logic [WIDTH-1:0] x_target_in;
    logic [WIDTH-1:0] y_target_in;

    logic [WIDTH-1:0] x_pos;
    logic [WIDTH-1:0] y_pos;
    logic [WIDTH-1:0] x_target;
    logic [WIDTH-1:0] y_target;
    logic             x_comp_eq;
    logic             x_comp_gt;
    logic             x_comp_lt;
    logic             y_comp_eq;
    logic             y_comp_gt;
    logic             y_comp_lt;
    logic             step_tick;

    modport master (
        output init, capt_enbl, x_count_en, x_up1_dwn0, y_count_en, y_up1_dwn0,
               x_target_in, y_target_in,
        input  x_pos, y_pos, x_target, y_target,
               x_comp_eq, x_comp_gt, x_comp_lt,
               y_comp_eq, y_comp_gt, y_comp_lt, step_tick
    );

    modport slave (
        input  init, capt_enbl, x_count_en, x_up1_dwn0, y_count_en, y_up1_dwn0,
               x_target_in, y_target_in,
        output x_pos, y_pos, x_target, y_target,
               x_comp_eq, x_comp_gt, x_comp_lt,
               y_comp_eq, y_comp_gt, y_comp_lt, step_tick
    );
endinterface

// File: rtl/xy_position_datapath.sv
// Purpose : Holds captured X/Y targets and X/Y position counters, steps the
//           positions at a prescaled rate under FSM command, and reports
//           unsigned eq/gt/lt comparisons of position against target.
// Ports   : clk   - system clock, rising-edge
//           reset - synchronous, active-high
//           bus   - slave side of xy_position_datapath_if (commands in,
//                   positions/targets/flags/step_tick out)
// Notes   : positions and targets are registered; comparator flags and
//           step_tick are combinational from registered state and enables.
module xy_position_datapath #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    xy_position_datapath_if.slave bus
);

    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0] POS_MAX   = '1;

    logic [WIDTH-1:0] x_pos_q, x_pos_d;
    logic [WIDTH-1:0] y_pos_q, y_pos_d;
    logic [WIDTH-1:0] x_tgt_q, x_tgt_d;
    logic [WIDTH-1:0] y_tgt_q, y_tgt_d;
    logic [PW-1:0]    presc_q, presc_d;

    logic any_en;
    logic at_max;
    logic step_tick_c;

    // Saturating one-unit move: never wraps past 0 or the all-ones value.
    function automatic logic [WIDTH-1:0] step_pos(input logic [WIDTH-1:0] pos,
                                                  input logic             up);
        logic [WIDTH-1:0] res;
        res = pos;
        if (up) begin
            if (pos != POS_MAX) res = pos + WIDTH'(1);
        end else begin
            if (pos != '0) res = pos - WIDTH'(1);
        end
        return res;
    endfunction

    assign any_en = bus.x_count_en | bus.y_count_en;
    assign at_max = (presc_q == PRESC_MAX);

    // A tick is suppressed whenever a higher-priority action owns the edge.
    assign step_tick_c = any_en & at_max & ~reset & ~bus.init & ~bus.capt_enbl;

    // Next-state: init > capture > counting > idle.
    always_comb begin
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        x_tgt_d = x_tgt_q;
        y_tgt_d = y_tgt_q;
        presc_d = presc_q;

        if (bus.init) begin
            x_pos_d = '0;
            y_pos_d = '0;
            x_tgt_d = '0;
            y_tgt_d = '0;
            presc_d = '0;
        end else if (bus.capt_enbl) begin
            x_tgt_d = bus.x_target_in;
            y_tgt_d = bus.y_target_in;
            presc_d = '0;
        end else if (any_en) begin
            if (at_max) begin
                presc_d = '0;
                if (bus.x_count_en) x_pos_d = step_pos(x_pos_q, bus.x_up1_dwn0);
                if (bus.y_count_en) y_pos_d = step_pos(y_pos_q, bus.y_up1_dwn0);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            // Losing both enables discards any partial prescale.
            presc_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos_q <= '0;
            y_pos_q <= '0;
            x_tgt_q <= '0;
            y_tgt_q <= '0;
            presc_q <= '0;
        end else begin
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
            x_tgt_q <= x_tgt_d;
            y_tgt_q <= y_tgt_d;
            presc_q <= presc_d;
        end
    end

    assign bus.x_pos     = x_pos_q;
    assign bus.y_pos     = y_pos_q;
    assign bus.x_target  = x_tgt_q;
    assign bus.y_target  = y_tgt_q;
    assign bus.step_tick = step_tick_c;

    // Unsigned comparators from registered state only.
    assign bus.x_comp_eq = (x_pos_q == x_tgt_q);
    assign bus.x_comp_gt = (x_pos_q >  x_tgt_q);
    assign bus.x_comp_lt = (x_pos_q <  x_tgt_q);
    assign bus.y_comp_eq = (y_pos_q == y_tgt_q);
    assign bus.y_comp_gt = (y_pos_q >  y_tgt_q);
    assign bus.y_comp_lt = (y_pos_q <  y_tgt_q);

endmodule
